// File: rtl/calc_request_sequencer_if.sv
// Bundles the operand stream, calculator handshake and result stream of calc_request_sequencer.
// The sequencer takes the master modport and its environment takes the slave modport.
interface calc_request_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [2*DATA_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic                calc_start;
  logic [DATA_W-1:0]   calc_a;
  logic [DATA_W-1:0]   calc_b;
  logic                calc_busy;
  logic [DATA_W-1:0]   calc_result;
  logic [DATA_W-1:0]   m_tdata;
  logic                m_tvalid;
  logic                m_tready;

  modport master (
    input  s_tdata, s_tvalid, calc_busy, calc_result, m_tready,
    output s_tready, calc_start, calc_a, calc_b, m_tdata, m_tvalid
  );

  modport slave (
    output s_tdata, s_tvalid, calc_busy, calc_result, m_tready,
    input  s_tready, calc_start, calc_a, calc_b, m_tdata, m_tvalid
  );
endinterface

// File: rtl/calc_request_sequencer.sv
// Serialises operand pairs into start/busy requests to the calculator service, one in flight,
// and queues each result in a small output FIFO; a watchdog aborts requests that never complete.
module calc_request_sequencer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  calc_request_sequencer_if.master  bus,
  output logic                      timeout_err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_ABORT   = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                s_tready_r;
  logic                calc_start_r;
  logic                timeout_err_r;
  logic [DATA_W-1:0]   calc_a_r;
  logic [DATA_W-1:0]   calc_b_r;
  logic [WD_W-1:0]     wd_r;
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_nxt_s;
  logic                accept_s;
  logic                wd_hit_s;
  logic                push_s;
  logic                pop_s;

  // s_tready is only ever high in IDLE, so it alone qualifies an accept.
  assign accept_s = s_tready_r & bus.s_tvalid;
  assign wd_hit_s = (wd_r == WD_LAST);
  assign push_s   = (state_r == ST_CAPTURE);
  assign pop_s    = (count_r != {CNT_W{1'b0}}) & bus.m_tready;

  // Next-state decode; a completing handshake takes priority over a same-cycle watchdog hit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_REQ;
        else          state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.calc_busy) state_s = ST_WAIT;
        else if (wd_hit_s) state_s = ST_ABORT;
        else               state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (!bus.calc_busy) state_s = ST_CAPTURE;
        else if (wd_hit_s)  state_s = ST_ABORT;
        else                state_s = ST_WAIT;
      end
      ST_CAPTURE: state_s = ST_GAP;
      ST_GAP:     state_s = ST_IDLE;
      ST_ABORT:   state_s = ST_GAP;
      default:    state_s = ST_IDLE;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s)      count_nxt_s = count_r + CNT_W'(1'b1);
    else if (!push_s && pop_s) count_nxt_s = count_r - CNT_W'(1'b1);
    else                       count_nxt_s = count_r;
  end

  // State register and registered handshake outputs, derived from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= ST_IDLE;
      s_tready_r    <= 1'b0;
      calc_start_r  <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      s_tready_r    <= (state_s == ST_IDLE) && (count_nxt_s < DEPTH_C);
      calc_start_r  <= (state_s == ST_REQ) || (state_s == ST_WAIT);
      if (state_s == ST_ABORT) timeout_err_r <= 1'b1;
    end
  end

  // Watchdog restarts on entry to REQ and again when busy is first seen.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_r <= {WD_W{1'b0}};
    end else if ((state_r == ST_IDLE && state_s == ST_REQ) ||
                 (state_r == ST_REQ  && state_s == ST_WAIT)) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == ST_REQ || state_r == ST_WAIT) begin
      wd_r <= wd_r + WD_W'(1'b1);
    end else begin
      wd_r <= {WD_W{1'b0}};
    end
  end

  // Operands are captured only at accept and held for the whole request.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      calc_a_r <= {DATA_W{1'b0}};
      calc_b_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      calc_a_r <= bus.s_tdata[DATA_W-1:0];
      calc_b_r <= bus.s_tdata[2*DATA_W-1:DATA_W];
    end
  end

  // Result FIFO; a slot was reserved at accept so the CAPTURE push never overflows.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.calc_result;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      count_r <= count_nxt_s;
    end
  end

  assign bus.s_tready   = s_tready_r;
  assign bus.calc_start = calc_start_r;
  assign bus.calc_a     = calc_a_r;
  assign bus.calc_b     = calc_b_r;
  assign bus.m_tdata    = mem_r[rd_ptr_r];
  assign bus.m_tvalid   = (count_r != {CNT_W{1'b0}});
  assign timeout_err    = timeout_err_r;
endmodule

// File: tb/tb_calc_request_sequencer.sv
// Directed and randomized bench for calc_request_sequencer with a behavioural calculator service
// and a queue of owed results as the reference.
module tb_calc_request_sequencer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic aclk;
  logic aresetn;
  logic timeout_err;

  calc_request_sequencer_if #(.DATA_W(DW)) bus ();

  calc_request_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(8)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  int          checks   = 0;
  int          failures = 0;
  int          svc_mode = 0;   // 0 normal, 1 never busy, 2 busy stuck high
  int          svc_lat  = 2;
  bit          rand_ready = 1'b0;
  bit          last_acc;
  logic [31:0] exp_q [$];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic logic [31:0] svc_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Calculator service: raises busy after seeing start, drops it with a result after svc_lat cycles.
  initial begin : service
    bit served;
    served = 1'b0;
    bus.calc_busy   = 1'b0;
    bus.calc_result = 32'h0;
    forever begin
      @(posedge aclk); #2;
      if (!bus.calc_start) begin
        served = 1'b0;
      end else if (!served) begin
        served = 1'b1;
        if (svc_mode == 0) begin
          bus.calc_busy = 1'b1;
          repeat (svc_lat) @(posedge aclk);
          #2;
          bus.calc_result = svc_fn(bus.calc_a, bus.calc_b);
          bus.calc_busy   = 1'b0;
        end else if (svc_mode == 2) begin
          bus.calc_busy = 1'b1;
          wait (svc_mode != 2);
          bus.calc_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: checks pops against the owed-result queue plus occupancy invariants.
  task automatic tick();
    logic        pop;
    logic [31:0] d;
    logic [31:0] e;
    if (rand_ready) bus.m_tready = 1'($urandom_range(0, 1));
    pop      = bus.m_tvalid && bus.m_tready && aresetn;
    d        = bus.m_tdata;
    last_acc = bus.s_tvalid && bus.s_tready && aresetn;
    @(posedge aclk); #1;
    if (pop) begin
      chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_data", d, e);
      end
    end
    if (aresetn && exp_q.size() == 0) chk("nothing_owed_mvalid", bus.m_tvalid, 1'b0);
    if (aresetn && exp_q.size() >= DEPTH) chk("full_no_tready", bus.s_tready, 1'b0);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input bit exp_push);
    bit done;
    done = 1'b0;
    bus.s_tdata  = {b, a};
    bus.s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (last_acc) done = 1'b1;
    end
    bus.s_tvalid = 1'b0;
    chk("accept", done, 1'b1);
    if (done && exp_push) exp_q.push_back(svc_fn(a, b));
  endtask

  task automatic drain(input string tag);
    bus.m_tready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick();
    chk({tag, "_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_mvalid"}, bus.m_tvalid, 1'b0);
    bus.m_tready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          npop;

    aresetn      = 1'b0;
    bus.s_tdata  = 64'h0;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_tready", bus.s_tready, 1'b0);
    chk("rst_calc_start", bus.calc_start, 1'b0);
    chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_calc_a", bus.calc_a, 32'h0);
    aresetn = 1'b1;
    tick();
    chk("idle_s_tready", bus.s_tready, 1'b1);

    // 1: single request, cycle-exact handshake
    send_pair(32'h3F80_0000, 32'h4000_0000, 1'b1);
    chk("t1_start_e0", bus.calc_start, 1'b1);
    chk("t1_calc_a", bus.calc_a, 32'h3F80_0000);
    chk("t1_calc_b", bus.calc_b, 32'h4000_0000);
    chk("t1_tready_e0", bus.s_tready, 1'b0);
    tick(); tick();
    chk("t1_start_e2", bus.calc_start, 1'b1);
    tick();
    chk("t1_start_drop", bus.calc_start, 1'b0);
    chk("t1_mvalid_e3", bus.m_tvalid, 1'b0);
    tick();
    chk("t1_mvalid_e4", bus.m_tvalid, 1'b1);
    chk("t1_mdata", bus.m_tdata, 32'h4040_0000);
    chk("t1_tready_gap", bus.s_tready, 1'b0);
    tick();
    chk("t1_tready_idle", bus.s_tready, 1'b1);
    bus.m_tready = 1'b1;
    tick();
    bus.m_tready = 1'b0;
    chk("t1_mvalid_after_pop", bus.m_tvalid, 1'b0);

    // 2: fill the FIFO, fifth pair blocked until the first pop
    for (int i = 0; i < 4; i++) send_pair($urandom, $urandom, 1'b1);
    repeat (6) tick();
    chk("t2_mvalid_full", bus.m_tvalid, 1'b1);
    a = $urandom;
    b = $urandom;
    bus.s_tdata  = {b, a};
    bus.s_tvalid = 1'b1;
    npop = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_acc) npop++;
    end
    chk("t2_no_accept_full", npop, 0);
    bus.m_tready = 1'b1;
    tick();
    bus.m_tready = 1'b0;
    chk("t2_tready_after_pop", bus.s_tready, 1'b1);
    tick();
    chk("t2_fifth_accept", last_acc, 1'b1);
    if (last_acc) exp_q.push_back(svc_fn(a, b));
    bus.s_tvalid = 1'b0;
    drain("t2_drain");

    // 3: simultaneous push and pop at count 2, enough times to wrap the pointers
    send_pair($urandom, $urandom, 1'b1);
    send_pair($urandom, $urandom, 1'b1);
    for (int k = 0; k < 6; k++) begin
      send_pair($urandom, $urandom, 1'b1);
      repeat (3) tick();
      bus.m_tready = 1'b1;
      tick();
      bus.m_tready = 1'b0;
      chk("t3_mvalid_pp", bus.m_tvalid, 1'b1);
    end
    repeat (2) tick();
    bus.m_tready = 1'b1;
    npop = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_tvalid) npop++;
      tick();
    end
    bus.m_tready = 1'b0;
    chk("t3_count_two", npop, 2);
    chk("t3_all_popped", 64'(exp_q.size()), 64'd0);

    // 5: busy stuck high in WAIT
    chk("t5_err_before", timeout_err, 1'b0);
    svc_mode = 2;
    send_pair($urandom, $urandom, 1'b0);
    chk("t5_start_e0", bus.calc_start, 1'b1);
    repeat (8) tick();
    chk("t5_start_e8", bus.calc_start, 1'b1);
    chk("t5_err_e8", timeout_err, 1'b0);
    tick();
    chk("t5_start_abort", bus.calc_start, 1'b0);
    chk("t5_err_abort", timeout_err, 1'b1);
    repeat (2) tick();
    chk("t5_tready_idle", bus.s_tready, 1'b1);
    chk("t5_no_write", bus.m_tvalid, 1'b0);
    svc_mode = 0;
    repeat (2) tick();

    // 6: reset in WAIT with two queued results
    svc_lat = 2;
    send_pair($urandom, $urandom, 1'b1);
    send_pair($urandom, $urandom, 1'b1);
    svc_lat = 30;
    send_pair($urandom, $urandom, 1'b0);
    repeat (3) tick();
    chk("t6_start_wait", bus.calc_start, 1'b1);
    chk("t6_mvalid_pre", bus.m_tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_start_rst", bus.calc_start, 1'b0);
    chk("t6_tready_rst", bus.s_tready, 1'b0);
    chk("t6_mvalid_rst", bus.m_tvalid, 1'b0);
    chk("t6_mdata_rst", bus.m_tdata, 32'h0);
    chk("t6_calc_a_rst", bus.calc_a, 32'h0);
    chk("t6_calc_b_rst", bus.calc_b, 32'h0);
    chk("t6_err_rst", timeout_err, 1'b0);
    repeat (2) tick();
    aresetn = 1'b1;
    chk("t6_tready_release", bus.s_tready, 1'b0);
    tick();
    chk("t6_tready_next", bus.s_tready, 1'b1);
    chk("t6_mvalid_next", bus.m_tvalid, 1'b0);
    npop = 0;
    for (int i = 0; i < 60 && bus.calc_busy; i++) tick();
    chk("t6_busy_done", bus.calc_busy, 1'b0);
    chk("t6_tready_stale", bus.s_tready, 1'b1);
    svc_lat = 2;

    // 4: service never raises busy
    svc_mode = 1;
    send_pair($urandom, $urandom, 1'b0);
    repeat (7) tick();
    chk("t4_start_e7", bus.calc_start, 1'b1);
    chk("t4_err_e7", timeout_err, 1'b0);
    tick();
    chk("t4_start_abort", bus.calc_start, 1'b0);
    chk("t4_err_abort", timeout_err, 1'b1);
    repeat (2) tick();
    chk("t4_tready_idle", bus.s_tready, 1'b1);
    chk("t4_no_write", bus.m_tvalid, 1'b0);
    svc_mode = 0;
    send_pair($urandom, $urandom, 1'b1);
    drain("t4_next");
    chk("t4_err_sticky", timeout_err, 1'b1);

    // randomized traffic with random latency and back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      svc_lat = $urandom_range(1, 5);
      send_pair($urandom, $urandom, 1'b1);
    end
    rand_ready = 1'b0;
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
